// File: rtl/gray_pkg.sv
// Shared definitions for the gray decoder pipeline: default width and the
// popcount helper used by the optional GRAY_STEP_CHECK_EN step check.
package gray_pkg;

    localparam int DEFAULT_WIDTH = 3;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all
// gray bits at or above its position.
module gray_to_bin #(
    parameter int width = 3
) (
    input  logic [width-1:0] gray,
    output logic [width-1:0] bin
);

    for (genvar i = 0; i < width; i++) begin : g_bit
        assign bin[i] = ^gray[width-1:i];
    end

endmodule

// File: rtl/gray_decoder_pipe.sv
// Two-stage valid/ready gray-to-binary decoder (stage 1 holds gray, stage 2
// holds binary). Optional sticky step checker enabled by GRAY_STEP_CHECK_EN.
module gray_decoder_pipe
    import gray_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] bin_out
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic             step_err
`endif
);

    logic             s1_valid_r;
    logic [width-1:0] s1_gray_r;
    logic             s2_valid_r;
    logic [width-1:0] s2_bin_r;
    logic [width-1:0] dec_s;
    logic             adv_s;
    logic             in_ready_s;
    logic             accept_s;

    gray_to_bin #(.width(width)) u_dec (
        .gray (s1_gray_r),
        .bin  (dec_s)
    );

    // Pipeline advance and input acceptance; in_ready is held low during reset.
    always_comb begin
        adv_s      = !s2_valid_r || out_ready;
        in_ready_s = rst_n && (!s1_valid_r || adv_s);
        accept_s   = in_valid && in_ready_s;
    end

    // Stage 1: capture the incoming gray word whenever the slot frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_gray_r  <= '0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_gray_r <= gray_in;
            end
        end
    end

    // Stage 2: capture the decoded word when empty or being consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_bin_r   <= '0;
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_bin_r <= dec_s;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign bin_out   = s2_bin_r;

`ifdef GRAY_STEP_CHECK_EN
    logic [width-1:0] prev_r;
    logic             have_prev_r;
    logic             step_err_r;
    logic [31:0]      diff_s;

    // Difference between the offered word and the last accepted one.
    always_comb begin
        diff_s            = 32'd0;
        diff_s[width-1:0] = gray_in ^ prev_r;
    end

    // The first word after reset only seeds prev_r; later words are compared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r      <= '0;
            have_prev_r <= 1'b0;
            step_err_r  <= 1'b0;
        end else if (accept_s) begin
            prev_r      <= gray_in;
            have_prev_r <= 1'b1;
            if (have_prev_r && (popcount(diff_s) > 6'd1)) begin
                step_err_r <= 1'b1;
            end
        end
    end

    assign step_err = step_err_r;
`endif

endmodule

// File: tb/tb_gray_decoder_pipe.sv
// Self-checking bench for gray_decoder_pipe: directed table at width 3,
// hand-written backpressure/reset sequences, and a random stream at width 8.
module tb_gray_decoder_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] gray_in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] bin_out;

    logic       in_valid8;
    logic       in_ready8;
    logic [7:0] gray8;
    logic       out_valid8;
    logic       out_ready8;
    logic [7:0] bin8;
`ifdef GRAY_STEP_CHECK_EN
    logic       step_err;
    logic       step_err8;
`endif

    int checks;
    int failures;
    int cyc;

    logic [2:0] got[$];
    int         got_cyc[$];
    int         acc_cyc[$];
    logic [7:0] exp8[$];
    int         sent8;
    int         recv8;

    typedef struct {
        logic [2:0] gray;
        logic [2:0] bin;
    } vec_t;
    vec_t tbl[8];

    gray_decoder_pipe #(.width(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray_in   (gray_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out)
`ifdef GRAY_STEP_CHECK_EN
        ,
        .step_err  (step_err)
`endif
    );

    gray_decoder_pipe #(.width(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .gray_in   (gray8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .bin_out   (bin8)
`ifdef GRAY_STEP_CHECK_EN
        ,
        .step_err  (step_err8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_dec(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got.delete();
        got_cyc.delete();
        acc_cyc.delete();
    endtask

    // Width-3 monitor: log accepted inputs and consumed outputs with cycle stamps.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got.push_back(bin_out);
            got_cyc.push_back(cyc);
        end
        if (rst_n && in_valid && in_ready) begin
            acc_cyc.push_back(cyc);
        end
    end

    // Width-8 scoreboard: reference decode on accept, compare in order on output.
    always @(negedge clk) begin
        if (rst_n && in_valid8 && in_ready8) begin
            exp8.push_back(ref_dec(gray8));
            sent8 = sent8 + 1;
        end
        if (rst_n && out_valid8 && out_ready8) begin
            recv8 = recv8 + 1;
            if (exp8.size() == 0) begin
                check("w8_unexpected_word", 64'(bin8), 64'hFFFF);
            end else begin
                check("w8_stream", 64'(bin8), 64'(exp8.pop_front()));
            end
        end
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; sent8 = 0; recv8 = 0;
        tbl[0] = '{3'b000, 3'b000}; tbl[1] = '{3'b001, 3'b001};
        tbl[2] = '{3'b011, 3'b010}; tbl[3] = '{3'b010, 3'b011};
        tbl[4] = '{3'b110, 3'b100}; tbl[5] = '{3'b111, 3'b101};
        tbl[6] = '{3'b101, 3'b110}; tbl[7] = '{3'b100, 3'b111};

        rst_n = 1'b0; in_valid = 1'b0; gray_in = 3'b000; out_ready = 1'b1;
        in_valid8 = 1'b0; gray8 = 8'h00; out_ready8 = 1'b1;
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_bin_out", 64'(bin_out), 64'd0);
`ifdef GRAY_STEP_CHECK_EN
        check("rst_step_err", 64'(step_err), 64'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Full-rate stream through the table.
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            gray_in  = tbl[i].gray;
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        check("stream_count", 64'(got.size()), 64'd8);
        check("stream_accepts", 64'(acc_cyc.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) check("stream_word", 64'(got[i]), 64'(tbl[i].bin));
        end
        if (got.size() == 8 && acc_cyc.size() == 8) begin
            check("first_latency", 64'(got_cyc[0] - acc_cyc[0]), 64'd2);
            check("no_gaps", 64'(got_cyc[7] - got_cyc[0]), 64'd7);
        end

        // Backpressure: two words buffered, third refused, then drained in order.
        clear_logs();
        out_ready = 1'b0;
        in_valid = 1'b1; gray_in = 3'b110; tick();
        gray_in = 3'b010; tick();
        gray_in = 3'b111;
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_bin_hold", 64'(bin_out), 64'(3'b100));
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        check("bp_count", 64'(got.size()), 64'd2);
        if (got.size() >= 2) begin
            check("bp_first", 64'(got[0]), 64'(3'b100));
            check("bp_second", 64'(got[1]), 64'(3'b011));
        end
        check("bp_accepts", 64'(acc_cyc.size()), 64'd2);

        // Reset with words in flight: nothing may emerge afterwards.
        clear_logs();
        out_ready = 1'b0;
        in_valid = 1'b1; gray_in = 3'b111; tick();
        gray_in = 3'b101; tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_bin_out", 64'(bin_out), 64'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        check("midrst_no_output", 64'(got.size()), 64'd0);
        check("midrst_in_ready_back", 64'(in_ready), 64'd1);
        in_valid = 1'b1; gray_in = 3'b010; tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("midrst_after_count", 64'(got.size()), 64'd1);
        if (got.size() >= 1) check("midrst_after_word", 64'(got[0]), 64'(3'b011));

`ifdef GRAY_STEP_CHECK_EN
        // Illegal step sets the sticky flag; legal words afterwards keep it set.
        in_valid = 1'b1; gray_in = 3'b000; tick();
        check("step_seed_ok", 64'(step_err), 64'd0);
        gray_in = 3'b011; tick();
        check("step_err_set", 64'(step_err), 64'd1);
        gray_in = 3'b010; tick();
        gray_in = 3'b110; tick();
        in_valid = 1'b0;
        check("step_err_sticky", 64'(step_err), 64'd1);
        rst_n = 1'b0; #1;
        check("step_err_rst", 64'(step_err), 64'd0);
        tick(); rst_n = 1'b1; tick();
        in_valid = 1'b1;
        gray_in = 3'b001; tick();
        gray_in = 3'b001; tick();
        gray_in = 3'b011; tick();
        in_valid = 1'b0; tick();
        check("step_legal_repeat", 64'(step_err), 64'd0);
        rst_n = 1'b0; #1; tick(); rst_n = 1'b1; tick();
        in_valid = 1'b1; gray_in = 3'b110; tick();
        in_valid = 1'b0; tick();
        check("step_first_unchecked", 64'(step_err), 64'd0);
        repeat (3) tick();
`endif

        // Random handshake stream at width 8.
        for (int n = 0; n < 400; n++) begin
            in_valid8  = 1'($urandom_range(0, 1));
            gray8      = 8'($urandom);
            out_ready8 = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        repeat (6) tick();
        check("w8_all_received", 64'(recv8), 64'(sent8));
        check("w8_queue_empty", 64'(exp8.size()), 64'd0);
        check("w8_enough_traffic", 64'(sent8 > 50), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_decoder_pipe.md
GRAY_DECODER_PIPE -- requirements
Module: gray_decoder_pipe

Interface
REQ-001 SHALL have parameter: width, 3, bit width of gray input and binary output (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  gray_in holds a valid word.
REQ-005 SHALL have port: in_ready  output  1  block accepts gray_in this cycle.
REQ-006 SHALL have port: gray_in  input  width  gray-coded word.
REQ-007 SHALL have port: out_valid  output  1  bin_out holds a valid decoded word.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts bin_out this cycle.
REQ-009 SHALL have port: bin_out  output  width  binary decode of an accepted gray word.
REQ-010 SHALL have port: step_err  output  1  sticky gray-step violation flag; present only with GRAY_STEP_CHECK_EN.

Function
REQ-011 SHALL decode as bin[width-1] = gray[width-1] and bin[i] = bin[i+1] XOR gray[i] for i = width-2 down to 0.
REQ-012 SHALL use a two-register pipeline: stage 1 captures gray_in; stage 2 captures the decoded binary value.
REQ-013 SHALL accept a word on a cycle where in_valid and in_ready are both 1; handshake on the output side completes when out_valid and out_ready are both 1.
REQ-014 SHALL produce out_valid exactly 2 cycles after acceptance when out_ready stays 1.
REQ-015 SHALL advance stage 2 when it is empty or its word is being consumed.
REQ-016 SHALL advance stage 1 into stage 2 under the same condition.
REQ-017 SHALL drive in_ready = (stage 1 empty) OR (stage 1 advancing this cycle); in_ready may depend combinationally on out_ready.
REQ-018 SHALL sustain one word per cycle with out_ready held 1, with no bubbles.
REQ-019 SHALL hold bin_out and out_valid stable while out_valid=1 and out_ready=0, and SHALL drop no word under backpressure.
REQ-020 SHALL buffer at most 2 words; with both stages full and out_ready=0, in_ready SHALL be 0.
REQ-021 SHALL preserve word order; no reordering or duplication.

Reset
REQ-022 SHALL, while rst_n=0, force out_valid=0, in_ready=0, both stage-valid flags=0, bin_out=0, step_err=0.
REQ-023 SHALL, on reset mid-operation, discard all in-flight words; none appears after release.
REQ-024 SHALL drive in_ready=1 on the first clock edge after rst_n deasserts.

Configuration
REQ-025 SHALL compile in step checking only when macro GRAY_STEP_CHECK_EN is defined.
REQ-026 With GRAY_STEP_CHECK_EN: for each accepted word, SHALL compute popcount(gray_in XOR previously accepted word); a result above 1 SHALL set step_err on the next edge.
REQ-027 With GRAY_STEP_CHECK_EN: step_err SHALL stay set until reset, and the first word after reset SHALL not be checked.
REQ-028 With GRAY_STEP_CHECK_EN: a repeated identical word (popcount 0) SHALL be legal.
REQ-029 Without GRAY_STEP_CHECK_EN: the step_err port, the previous-word register and the compare logic SHALL be absent; the datapath SHALL be unchanged.

Structure
REQ-030 SHALL place in shared package gray_pkg: DEFAULT_WIDTH=3 and a popcount function used by the step check.
REQ-031 SHALL instantiate one combinational sub-module, gray_to_bin (parameter width), implementing REQ-011 between stage 1 and stage 2.

Verification
REQ-032 Reset then, with out_ready=1, stream 000,001,011,010,110,111,101,100 one per cycle -> bin_out 0..7 in order, first out_valid 2 cycles after first accept, no gaps.
REQ-033 Send 110 with out_ready=0 for 5 cycles -> out_valid=1, bin_out=100 held; next word 010 buffered; in_ready=0 once both stages are full; on release -> 100 then 011.
REQ-034 Send 111 and 101, assert rst_n=0 for 1 cycle before output -> no out_valid after release; then send 010 -> bin_out=011.
REQ-035 GRAY_STEP_CHECK_EN: accept 000 then 011 -> step_err=1 one edge later and stays 1 through later legal words until reset.
REQ-036 GRAY_STEP_CHECK_EN: accept 001,001,011 -> step_err stays 0; reset, first word 110 -> step_err stays 0.
REQ-037 Random in_valid/out_ready at width=8 -> output sequence equals the reference decode of the input sequence, and no word is lost.
